// File: rtl/time_mod_cnt_if.sv
// rtl/time_mod_cnt_if.sv - control/status bundle for one modulo-N time-digit counter
interface time_mod_cnt_if #(
    parameter int WIDTH = 6
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] cnt;
    logic             carry;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             load_err;

    modport master (
        output clr, load, load_val, en, up_dn,
        input  cnt, carry, bcd_tens, bcd_ones, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up_dn,
        output cnt, carry, bcd_tens, bcd_ones, load_err
    );
endinterface

// File: rtl/time_mod_cnt.sv
// rtl/time_mod_cnt.sv - modulo-N up/down time-digit counter with carry pulse and BCD digits
module time_mod_cnt #(
    parameter int MODULO = 60,
    parameter int WIDTH  = 6
) (
    input  logic           inclk,
    input  logic           rst,
    time_mod_cnt_if.slave  bus
);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;
    logic [3:0]       bcd_tens_q, bcd_tens_d;
    logic [3:0]       bcd_ones_q, bcd_ones_d;
    logic [7:0]       cnt_ext;

    always_comb begin
        cnt_d      = cnt_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.load) begin
            if ({1'b0, bus.load_val} < MOD_EXT) begin
                cnt_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            // Wrap at MODULO, not at 2**WIDTH; carry doubles as borrow when counting down.
            if (bus.up_dn) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_MAX;
                    carry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // Digits derive from the next count so they land on the same edge as cnt.
    always_comb begin
        cnt_ext    = 8'(cnt_d);
        bcd_tens_d = 4'(cnt_ext / 8'd10);
        bcd_ones_d = 4'(cnt_ext % 8'd10);
    end

    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            bcd_tens_q <= 4'd0;
            bcd_ones_q <= 4'd0;
        end else begin
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
    assign bus.bcd_tens = bcd_tens_q;
    assign bus.bcd_ones = bcd_ones_q;
endmodule
